conv_2d_feeder: RTL
===================

CONV_2D_FEEDER -- requirements
Module: conv_2d_feeder

Interface
REQ-001 Parameter N, default 5: image is N x N pixels, N*N <= 256.
REQ-002 Parameter M, default 3: kernel is M x M coefficients, M <= N.
REQ-003 Parameter HOLD, default 2: clock cycles each element is held on a/b.
REQ-004 Parameter GAP, default 2: extra hold cycles after each image row except the last.
REQ-005 clk  input  1  single clock; all state on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 wr_en  input  1  load strobe for image/kernel storage.
REQ-008 wr_sel  input  1  0 = image memory, 1 = kernel memory.
REQ-009 wr_addr  input  8  element index, row-major.
REQ-010 wr_data  input  8  element value.
REQ-011 start  input  1  one-cycle request to stream stored data.
REQ-012 conv_done  input  1  completion flag from the downstream convolution engine.
REQ-013 a  output  8  serial image pixel to the engine.
REQ-014 b  output  8  serial kernel coefficient to the engine.
REQ-015 busy  output  1  high from stream start until completion.
REQ-016 done  output  1  one-cycle completion pulse.

Function
REQ-017 Storage: image RAM N*N x 8 and kernel RAM M*M x 8, both register-based.
REQ-018 Write: wr_en=1, busy=0 and wr_addr in range (image < N*N, kernel < M*M) -> store wr_data at that edge; otherwise the write is dropped.
REQ-019 FSM states: IDLE, FEED, GAP, WAIT, FIN.
REQ-020 IDLE: a=0, b=0, busy=0; start=1 -> FEED with index i=0, busy=1 from the next cycle.
REQ-021 start in the same cycle as an accepted write: both take effect; the stream uses the newly written value.
REQ-022 FEED: a=img[i]; b=ker[i] for i < M*M, else b=0; each element is held exactly HOLD cycles.
REQ-023 After HOLD: if (i+1) mod N = 0 and i < N*N-1 -> GAP; else if i = N*N-1 -> WAIT; else i increments and FSM stays in FEED.
REQ-024 GAP: a/b keep element i for GAP further cycles, then i increments -> FEED; GAP=0 skips the state.
REQ-025 Total FEED+GAP cycles = N*N*HOLD + (N-1)*GAP (58 at defaults).
REQ-026 WAIT: a=0, b=0, busy=1; conv_done sampled high -> FIN.
REQ-027 conv_done outside WAIT is ignored (not latched).
REQ-028 FIN: lasts one cycle with done=1 and busy=0, then IDLE.
REQ-029 start while busy=1 or in FIN is ignored.
REQ-030 Index counter width is 8 bits; hold counter width is sized for max(HOLD, GAP); no wrap occurs within legal parameters.
REQ-031 a and b are registered outputs; no combinational path from any input to any output.

Reset
REQ-032 rst=0 forces asynchronously: state=IDLE, a=0, b=0, busy=0, done=0, counters=0, all RAM entries=0.
REQ-033 Reset mid-stream aborts immediately with no done pulse; after rst returns to 1 the block waits for a new start.
REQ-034 Operation resumes on the first rising clk edge after rst deasserts.

Verification
REQ-035 Load image 1..25 and kernel {1,0,1,1,1,1,0,1,0}, pulse start -> a steps 1,2,...,25 every 2 cycles with 2 extra cycles after 5, 10, 15, 20; b follows the kernel for the first 9 elements, then 0; 58 feed cycles total.
REQ-036 After the stream, hold conv_done=0 for 10 cycles, then assert it -> busy stays 1 and a=b=0 throughout, then one done pulse, then busy=0.
REQ-037 Pulse start and write image[0]=99 during FEED, and pulse conv_done during FEED -> start, write and conv_done are all ignored; the stream and the stored data are unchanged.
REQ-038 Same-cycle start and write image[0]=7 in IDLE -> the first a value is 7.
REQ-039 Assert rst=0 at i=12 -> a=b=busy=0 asynchronously, no done pulse, RAM cleared; a subsequent start streams zeros.
REQ-040 Write kernel addr 9 and image addr 25 -> both are dropped; the stored contents are unchanged.

Source files
------------

// File: rtl/conv_2d_feeder.sv
// Streams a stored N x N image and M x M kernel element-by-element to a
// downstream convolution engine. Each element is held HOLD cycles, with GAP
// extra cycles at the end of every image row but the last. After the stream
// the block waits for conv_done and then emits a one-cycle done pulse.
// a, b, busy and done are registered and track the state register directly,
// so the values driven in a cycle always correspond to that cycle's state.
module conv_2d_feeder #(
    parameter int N    = 5,
    parameter int M    = 3,
    parameter int HOLD = 2,
    parameter int GAP  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       conv_done,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       busy,
    output logic       done
);

    localparam int IMG_SZ = N * N;
    localparam int KER_SZ = M * M;
    localparam int HMAX   = (HOLD > GAP) ? HOLD : GAP;
    localparam int HW     = (HMAX < 2) ? 1 : $clog2(HMAX);

    localparam logic [8:0]    IMG_SZ_W  = 9'(IMG_SZ);
    localparam logic [8:0]    KER_SZ_W  = 9'(KER_SZ);
    localparam logic [8:0]    N_W       = 9'(N);
    localparam logic [7:0]    LAST_IDX  = 8'(IMG_SZ - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [HW-1:0] GAP_LAST  = HW'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FEED = 3'd1,
        S_GAP  = 3'd2,
        S_WAIT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [7:0]      idx_r;
    logic [7:0]      idx_nxt_s;
    logic [8:0]      idx_plus_s;
    logic [HW-1:0]   hold_r;
    logic [HW-1:0]   hold_nxt_s;
    logic            row_end_s;

    logic [7:0]      img_mem_r [IMG_SZ];
    logic [7:0]      ker_mem_r [KER_SZ];
    logic            img_we_s;
    logic            ker_we_s;
    logic [7:0]      img_rd_s;
    logic [7:0]      ker_rd_s;
    logic [7:0]      a_nxt_s;
    logic [7:0]      b_nxt_s;
    logic            feeding_nxt_s;

    // Write qualification: only while not busy and only for in-range addresses.
    always_comb begin
        img_we_s = wr_en & ~busy & ~wr_sel & ({1'b0, wr_addr} < IMG_SZ_W);
        ker_we_s = wr_en & ~busy &  wr_sel & ({1'b0, wr_addr} < KER_SZ_W);
    end

    // Row-end detection for the element currently being fed.
    always_comb begin
        idx_plus_s = {1'b0, idx_r} + 9'd1;
        row_end_s  = ((idx_plus_s % N_W) == 9'd0) && (idx_r != LAST_IDX);
    end

    // Next-state, index and hold-counter logic of the stream FSM.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        hold_nxt_s  = hold_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = S_FEED;
                    idx_nxt_s   = 8'd0;
                    hold_nxt_s  = '0;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FEED: begin
                if (hold_r == HOLD_LAST) begin
                    hold_nxt_s = '0;
                    if (row_end_s) begin
                        if (GAP > 0) begin
                            state_nxt_s = S_GAP;
                        end else begin
                            idx_nxt_s = idx_plus_s[7:0];
                        end
                    end else if (idx_r == LAST_IDX) begin
                        state_nxt_s = S_WAIT;
                    end else begin
                        idx_nxt_s = idx_plus_s[7:0];
                    end
                end else begin
                    hold_nxt_s = hold_r + HW'(1);
                end
            end
            S_GAP: begin
                if (hold_r == GAP_LAST) begin
                    hold_nxt_s  = '0;
                    idx_nxt_s   = idx_plus_s[7:0];
                    state_nxt_s = S_FEED;
                end else begin
                    hold_nxt_s = hold_r + HW'(1);
                end
            end
            S_WAIT: begin
                if (conv_done) begin
                    state_nxt_s = S_FIN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_FIN: begin
                state_nxt_s = S_IDLE;
                idx_nxt_s   = 8'd0;
                hold_nxt_s  = '0;
            end
            default: begin
                state_nxt_s = S_IDLE;
                idx_nxt_s   = 8'd0;
                hold_nxt_s  = '0;
            end
        endcase
    end

    // Memory read at the next index, forwarding a same-cycle accepted write.
    always_comb begin
        img_rd_s = 8'd0;
        ker_rd_s = 8'd0;
        for (int k = 0; k < IMG_SZ; k++) begin
            img_rd_s = (idx_nxt_s == 8'(k)) ? img_mem_r[k] : img_rd_s;
        end
        for (int k = 0; k < KER_SZ; k++) begin
            ker_rd_s = (idx_nxt_s == 8'(k)) ? ker_mem_r[k] : ker_rd_s;
        end
        if (img_we_s && (wr_addr == idx_nxt_s)) begin
            img_rd_s = wr_data;
        end else begin
            img_rd_s = img_rd_s;
        end
        if (ker_we_s && (wr_addr == idx_nxt_s)) begin
            ker_rd_s = wr_data;
        end else begin
            ker_rd_s = ker_rd_s;
        end
    end

    // Output values for the upcoming state; zero outside FEED/GAP.
    always_comb begin
        a_nxt_s       = 8'd0;
        b_nxt_s       = 8'd0;
        feeding_nxt_s = (state_nxt_s == S_FEED) || (state_nxt_s == S_GAP);
        if (feeding_nxt_s) begin
            a_nxt_s = img_rd_s;
            b_nxt_s = ({1'b0, idx_nxt_s} < KER_SZ_W) ? ker_rd_s : 8'd0;
        end else begin
            a_nxt_s = 8'd0;
            b_nxt_s = 8'd0;
        end
    end

    // FSM state, element index and hold counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            idx_r   <= 8'd0;
            hold_r  <= '0;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            hold_r  <= hold_nxt_s;
        end
    end

    // Register-based image and kernel storage, cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < IMG_SZ; k++) img_mem_r[k] <= 8'd0;
            for (int k = 0; k < KER_SZ; k++) ker_mem_r[k] <= 8'd0;
        end else begin
            for (int k = 0; k < IMG_SZ; k++) begin
                if (img_we_s && (wr_addr == 8'(k))) img_mem_r[k] <= wr_data;
            end
            for (int k = 0; k < KER_SZ; k++) begin
                if (ker_we_s && (wr_addr == 8'(k))) ker_mem_r[k] <= wr_data;
            end
        end
    end

    // Registered outputs aligned with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a    <= 8'd0;
            b    <= 8'd0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            a    <= a_nxt_s;
            b    <= b_nxt_s;
            busy <= feeding_nxt_s || (state_nxt_s == S_WAIT);
            done <= (state_nxt_s == S_FIN);
        end
    end

endmodule
